// File: rtl/rf_write_arbiter.sv
// Single register-file write port shared between an unbuffered priority writer (A)
// and a FIFO-queued long-latency writer (B), with starvation forcing and stale-head dropping.
module rf_write_arbiter #(
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter int unsigned STARVE_LIM   = 3,
    parameter bit          R0_HARDWIRED = 1'b1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          a_valid,
    output logic                          a_ready,
    input  logic [3:0]                    a_reg,
    input  logic [15:0]                   a_data,
    input  logic                          b_valid,
    output logic                          b_ready,
    input  logic [3:0]                    b_reg,
    input  logic [15:0]                   b_data,
    output logic                          rf_we,
    output logic [3:0]                    rf_dst,
    output logic [15:0]                   rf_data,
    output logic [$clog2(FIFO_DEPTH):0]   b_count
);

    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned SW = $clog2(STARVE_LIM + 1);

    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_A,
        GNT_B
    } grant_e;

    logic [3:0]    fifo_reg  [FIFO_DEPTH];
    logic [15:0]   fifo_data [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   count;
    logic [SW-1:0] starve_cnt;

    grant_e        grant;
    logic          empty;
    logic          full;
    logic          force_b;
    logic          collision;
    logic          push;
    logic          pop;
    logic [3:0]    head_reg;
    logic [15:0]   head_data;
    logic [3:0]    win_reg;
    logic [15:0]   win_data;
    logic          win_we;

    assign empty     = (count == '0);
    assign full      = (count == (PW + 1)'(FIFO_DEPTH));
    assign head_reg  = fifo_reg[rd_ptr];
    assign head_data = fifo_data[rd_ptr];
    assign force_b   = (starve_cnt == SW'(STARVE_LIM)) && !empty;
    assign a_ready   = !force_b;
    assign b_ready   = !full;
    assign b_count   = count;

    always_comb begin
        grant = GNT_NONE;
        if (force_b)
            grant = GNT_B;
        else if (a_valid)
            grant = GNT_A;
        else if (!empty)
            grant = GNT_B;
    end

    // An A write to the same register makes the queued head obsolete, so it is dropped.
    assign collision = (grant == GNT_A) && !empty && (head_reg == a_reg);
    assign push      = b_valid && !full;
    assign pop       = (grant == GNT_B) || collision;

    always_comb begin
        win_reg  = a_reg;
        win_data = a_data;
        if (grant == GNT_B) begin
            win_reg  = head_reg;
            win_data = head_data;
        end
        win_we = (grant != GNT_NONE) && !(R0_HARDWIRED && (win_reg == 4'd0));
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_reg[wr_ptr]  <= b_reg;
            fifo_data[wr_ptr] <= b_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PW'(1);
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + (PW + 1)'(1);
                2'b01:   count <= count - (PW + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            starve_cnt <= '0;
        else if (pop || empty)
            starve_cnt <= '0;
        else if ((grant == GNT_A) && (starve_cnt != SW'(STARVE_LIM)))
            starve_cnt <= starve_cnt + SW'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rf_we   <= 1'b0;
            rf_dst  <= '0;
            rf_data <= '0;
        end else begin
            rf_we <= win_we;
            if (win_we) begin
                rf_dst  <= win_reg;
                rf_data <= win_data;
            end
        end
    end

    a_pop_nonempty: assert property (@(posedge clk) disable iff (!rst_n) pop |-> !empty);
    a_count_bound:  assert property (@(posedge clk) disable iff (!rst_n) count <= (PW + 1)'(FIFO_DEPTH));

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Bench for rf_write_arbiter: expected port writes are queued as stimulus is applied
// and matched in order against rf_we pulses; a small register file tracks committed values.
module tb_rf_write_arbiter;

    logic        clk;
    logic        rst_n;
    logic        a_valid;
    logic        a_ready;
    logic [3:0]  a_reg;
    logic [15:0] a_data;
    logic        b_valid;
    logic        b_ready;
    logic [3:0]  b_reg;
    logic [15:0] b_data;
    logic        rf_we;
    logic [3:0]  rf_dst;
    logic [15:0] rf_data;
    logic [2:0]  b_count;

    typedef struct packed {
        logic [3:0]  dst;
        logic [15:0] data;
    } wr_t;

    wr_t         exp_q[$];
    logic [15:0] rf_model [16];
    int          checks;
    int          passed;

    rf_write_arbiter #(
        .FIFO_DEPTH  (4),
        .STARVE_LIM  (3),
        .R0_HARDWIRED(1'b1)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .a_valid(a_valid),
        .a_ready(a_ready),
        .a_reg  (a_reg),
        .a_data (a_data),
        .b_valid(b_valid),
        .b_ready(b_ready),
        .b_reg  (b_reg),
        .b_data (b_data),
        .rf_we  (rf_we),
        .rf_dst (rf_dst),
        .rf_data(rf_data),
        .b_count(b_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        for (int i = 0; i < 16; i++)
            rf_model[i] = 16'h0000;
    end

    always @(posedge clk) begin
        if (rf_we === 1'b1)
            rf_model[rf_dst] <= rf_data;
    end

    // Every write-port pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rf_we === 1'b1) begin
            wr_t e;
            checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL port_write: unexpected write dst=%0d data=%h, required none", rf_dst, rf_data);
            end else begin
                e = exp_q.pop_front();
                if (rf_dst !== e.dst || rf_data !== e.data)
                    $display("FAIL port_write: got dst=%0d data=%h, required dst=%0d data=%h",
                             rf_dst, rf_data, e.dst, e.data);
                else
                    passed++;
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_write(input logic [3:0] dst, input logic [15:0] data);
        wr_t e;
        e.dst  = dst;
        e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic test_reset;
        rst_n   = 1'b0;
        a_valid = 1'b1;
        a_reg   = 4'd1;
        a_data  = 16'hDEAD;
        b_valid = 1'b1;
        b_reg   = 4'd2;
        b_data  = 16'hBEEF;
        tick();
        tick();
        checks++;
        if (rf_we !== 1'b0) $display("FAIL reset_we: got %b, required 0", rf_we); else passed++;
        checks++;
        if (b_count !== 3'd0) $display("FAIL reset_count: got %0d, required 0", b_count); else passed++;
        checks++;
        if (b_ready !== 1'b1) $display("FAIL reset_bready: got %b, required 1", b_ready); else passed++;
        checks++;
        if (rf_dst !== 4'd0 || rf_data !== 16'h0000)
            $display("FAIL reset_port: got dst=%0d data=%h, required 0/0000", rf_dst, rf_data);
        else passed++;
        a_valid = 1'b0;
        b_valid = 1'b0;
        rst_n   = 1'b1;
        tick();
    endtask

    task automatic test_a_only;
        a_valid = 1'b1;
        a_reg   = 4'd7;
        a_data  = 16'h3099;
        checks++;
        if (a_ready !== 1'b1) $display("FAIL a_only_ready: got %b, required 1", a_ready); else passed++;
        expect_write(4'd7, 16'h3099);
        tick();
        a_valid = 1'b0;
        checks++;
        if (rf_we !== 1'b1) $display("FAIL a_only_we: got %b, required 1", rf_we); else passed++;
        tick();
        checks++;
        if (rf_we !== 1'b0) $display("FAIL a_only_idle_we: got %b, required 0", rf_we); else passed++;
        checks++;
        if (rf_dst !== 4'd7 || rf_data !== 16'h3099)
            $display("FAIL a_only_hold: got dst=%0d data=%h, required 7/3099", rf_dst, rf_data);
        else passed++;
        checks++;
        if (rf_model[7] !== 16'h3099) $display("FAIL a_only_r7: got %h, required 3099", rf_model[7]); else passed++;
    endtask

    task automatic test_starvation;
        b_valid = 1'b1;
        b_reg   = 4'd5;
        b_data  = 16'hA173;
        tick();
        b_valid = 1'b0;
        checks++;
        if (b_count !== 3'd1) $display("FAIL starve_push_count: got %0d, required 1", b_count); else passed++;
        a_valid = 1'b1;
        a_reg   = 4'd2;
        a_data  = 16'h2222;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (a_ready !== 1'b1) $display("FAIL starve_a_win%0d: a_ready got %b, required 1", i, a_ready); else passed++;
            expect_write(4'd2, 16'h2222);
            tick();
        end
        checks++;
        if (a_ready !== 1'b0) $display("FAIL starve_force: a_ready got %b, required 0", a_ready); else passed++;
        expect_write(4'd5, 16'hA173);
        tick();
        checks++;
        if (a_ready !== 1'b1) $display("FAIL starve_resume: a_ready got %b, required 1", a_ready); else passed++;
        expect_write(4'd2, 16'h2222);
        tick();
        a_valid = 1'b0;
        tick();
        checks++;
        if (b_count !== 3'd0) $display("FAIL starve_drained: got %0d, required 0", b_count); else passed++;
    endtask

    task automatic test_fifo_full;
        for (int i = 0; i < 4; i++) begin
            a_valid = 1'b1;
            a_reg   = 4'd9;
            a_data  = 16'h9000 + 16'(i);
            b_valid = 1'b1;
            b_reg   = 4'(10 + i);
            b_data  = 16'hB000 + 16'(i);
            checks++;
            if (b_ready !== 1'b1) $display("FAIL full_push%0d_ready: got %b, required 1", i, b_ready); else passed++;
            expect_write(4'd9, 16'h9000 + 16'(i));
            tick();
        end
        checks++;
        if (b_ready !== 1'b0) $display("FAIL full_bready: got %b, required 0", b_ready); else passed++;
        checks++;
        if (b_count !== 3'd4) $display("FAIL full_count: got %0d, required 4", b_count); else passed++;
        a_valid = 1'b0;
        b_reg   = 4'd14;
        b_data  = 16'hB004;
        expect_write(4'd10, 16'hB000);
        tick();
        checks++;
        if (b_ready !== 1'b1 || b_count !== 3'd3)
            $display("FAIL full_first_pop: got ready=%b count=%0d, required 1/3", b_ready, b_count);
        else passed++;
        expect_write(4'd11, 16'hB001);
        tick();
        b_valid = 1'b0;
        checks++;
        if (b_count !== 3'd3) $display("FAIL full_push_pop_count: got %0d, required 3", b_count); else passed++;
        expect_write(4'd12, 16'hB002);
        expect_write(4'd13, 16'hB003);
        expect_write(4'd14, 16'hB004);
        tick();
        tick();
        tick();
        checks++;
        if (b_count !== 3'd0) $display("FAIL full_drained: got %0d, required 0", b_count); else passed++;
        tick();
    endtask

    task automatic test_collision;
        a_valid = 1'b1;
        a_reg   = 4'd8;
        a_data  = 16'h8888;
        b_valid = 1'b1;
        b_reg   = 4'd3;
        b_data  = 16'h1111;
        expect_write(4'd8, 16'h8888);
        tick();
        b_reg   = 4'd4;
        b_data  = 16'h4444;
        expect_write(4'd8, 16'h8888);
        tick();
        b_valid = 1'b0;
        a_reg   = 4'd3;
        a_data  = 16'h808A;
        checks++;
        if (b_count !== 3'd2) $display("FAIL coll_pre_count: got %0d, required 2", b_count); else passed++;
        expect_write(4'd3, 16'h808A);
        tick();
        a_valid = 1'b0;
        checks++;
        if (b_count !== 3'd1) $display("FAIL coll_post_count: got %0d, required 1", b_count); else passed++;
        expect_write(4'd4, 16'h4444);
        tick();
        checks++;
        if (rf_model[3] !== 16'h808A) $display("FAIL coll_r3: got %h, required 808A", rf_model[3]); else passed++;
        tick();
        checks++;
        if (b_count !== 3'd0) $display("FAIL coll_drained: got %0d, required 0", b_count); else passed++;
    endtask

    task automatic test_r0;
        a_valid = 1'b1;
        a_reg   = 4'd0;
        a_data  = 16'hFFFF;
        checks++;
        if (a_ready !== 1'b1) $display("FAIL r0_a_ready: got %b, required 1", a_ready); else passed++;
        tick();
        a_valid = 1'b0;
        checks++;
        if (rf_we !== 1'b0) $display("FAIL r0_a_we: got %b, required 0", rf_we); else passed++;
        b_valid = 1'b1;
        b_reg   = 4'd0;
        b_data  = 16'h1234;
        tick();
        b_valid = 1'b0;
        tick();
        checks++;
        if (b_count !== 3'd0) $display("FAIL r0_b_popped: got %0d, required 0", b_count); else passed++;
        checks++;
        if (rf_we !== 1'b0) $display("FAIL r0_b_we: got %b, required 0", rf_we); else passed++;
        tick();
        checks++;
        if (rf_model[0] !== 16'h0000) $display("FAIL r0_unchanged: got %h, required 0000", rf_model[0]); else passed++;
    endtask

    initial begin
        checks  = 0;
        passed  = 0;
        rst_n   = 1'b0;
        a_valid = 1'b0;
        a_reg   = '0;
        a_data  = '0;
        b_valid = 1'b0;
        b_reg   = '0;
        b_data  = '0;
        test_reset();
        test_a_only();
        test_starvation();
        test_fifo_full();
        test_collision();
        test_r0();
        tick();
        tick();
        checks++;
        if (exp_q.size() != 0)
            $display("FAIL missing_writes: %0d outstanding, required 0", exp_q.size());
        else passed++;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
